line_cmd_sequencer: RTL and testbench

Command front-end for the line engine. Consumes a stream of 32-bit drawing command words (from the processor's MMIO command FIFO), assembles color and endpoint operands, and drives the line engine's load/trigger interface: color, point0, point1, trigger. It waits for the engine to finish each line before accepting the next command. It sits directly upstream of `LineEngine`; `LineEngine` still owns the DRAM FIFO side.

---
 rtl/line_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_line_cmd_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_cmd_sequencer.sv
// Command front-end for the line engine: assembles color/endpoint operands from a
// 32-bit command stream and drives the engine's load/trigger strobes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a command header
// GET_COLOR  | waiting for the SET_COLOR payload word
// GET_P0     | waiting for the LINE start-point word
// GET_P1     | waiting for the end-point word (LINE or LINETO)
// WAIT_LE    | operands complete, waiting for the engine to be ready
// SEND_COLOR | LE_color_valid strobe high
// SEND_P0    | LE_point0_valid strobe high
// SEND_P1    | LE_point1_valid strobe high
// TRIGGER    | LE_trigger pulse high
// HOLDOFF    | one dead cycle while the engine drops LE_ready
// WAIT_DONE  | waiting for the engine to finish the line

module line_cmd_sequencer #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          cmd_data,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 LE_ready,
   output logic [31:0]          LE_color,
   output logic [19:0]          LE_point,
   output logic                 LE_color_valid,
   output logic                 LE_point0_valid,
   output logic                 LE_point1_valid,
   output logic                 LE_trigger,
   output logic                 seq_busy,
   output logic                 seq_error,
   output logic [CNT_WIDTH-1:0] lines_drawn
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_GET_COLOR  = 4'd1;
   localparam logic [3:0] S_GET_P0     = 4'd2;
   localparam logic [3:0] S_GET_P1     = 4'd3;
   localparam logic [3:0] S_WAIT_LE    = 4'd4;
   localparam logic [3:0] S_SEND_COLOR = 4'd5;
   localparam logic [3:0] S_SEND_P0    = 4'd6;
   localparam logic [3:0] S_SEND_P1    = 4'd7;
   localparam logic [3:0] S_TRIGGER    = 4'd8;
   localparam logic [3:0] S_HOLDOFF    = 4'd9;
   localparam logic [3:0] S_WAIT_DONE  = 4'd10;

   localparam logic [7:0] OP_NOP       = 8'h00;
   localparam logic [7:0] OP_SET_COLOR = 8'h01;
   localparam logic [7:0] OP_LINE      = 8'h02;
   localparam logic [7:0] OP_LINETO    = 8'h03;

   logic [3:0]  state;
   logic [31:0] color;
   logic [19:0] p0;
   logic [19:0] p1;
   logic [19:0] last_end;
   logic [7:0]  opcode;

   assign opcode    = cmd_data[31:24];
   assign seq_busy  = (state != S_IDLE);
   assign cmd_ready = rst && ((state == S_IDLE) || (state == S_GET_COLOR) ||
                              (state == S_GET_P0) || (state == S_GET_P1));

   // Strobes are registered alongside the state, so each one is high exactly
   // while the FSM sits in the matching SEND_*/TRIGGER state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         color           <= '0;
         p0              <= '0;
         p1              <= '0;
         last_end        <= '0;
         LE_color        <= '0;
         LE_point        <= '0;
         LE_color_valid  <= 1'b0;
         LE_point0_valid <= 1'b0;
         LE_point1_valid <= 1'b0;
         LE_trigger      <= 1'b0;
         seq_error       <= 1'b0;
         lines_drawn     <= '0;
      end else begin
         LE_color_valid  <= 1'b0;
         LE_point0_valid <= 1'b0;
         LE_point1_valid <= 1'b0;
         LE_trigger      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (opcode)
                     OP_NOP:       state <= S_IDLE;
                     OP_SET_COLOR: state <= S_GET_COLOR;
                     OP_LINE:      state <= S_GET_P0;
                     OP_LINETO: begin
                        p0    <= last_end;
                        state <= S_GET_P1;
                     end
                     default:      seq_error <= 1'b1;
                  endcase
               end
            end
            S_GET_COLOR: begin
               if (cmd_valid) begin
                  color <= cmd_data;
                  state <= S_IDLE;
               end
            end
            S_GET_P0: begin
               if (cmd_valid) begin
                  p0    <= cmd_data[19:0];
                  state <= S_GET_P1;
               end
            end
            S_GET_P1: begin
               if (cmd_valid) begin
                  p1    <= cmd_data[19:0];
                  state <= S_WAIT_LE;
               end
            end
            S_WAIT_LE: begin
               if (LE_ready) begin
                  LE_color       <= color;
                  LE_color_valid <= 1'b1;
                  state          <= S_SEND_COLOR;
               end
            end
            S_SEND_COLOR: begin
               LE_point        <= p0;
               LE_point0_valid <= 1'b1;
               state           <= S_SEND_P0;
            end
            S_SEND_P0: begin
               LE_point        <= p1;
               LE_point1_valid <= 1'b1;
               state           <= S_SEND_P1;
            end
            S_SEND_P1: begin
               LE_trigger <= 1'b1;
               last_end   <= p1;
               state      <= S_TRIGGER;
            end
            S_TRIGGER: state <= S_HOLDOFF;
            S_HOLDOFF: state <= S_WAIT_DONE;
            S_WAIT_DONE: begin
               if (LE_ready) begin
                  lines_drawn <= lines_drawn + CNT_WIDTH'(1);
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Randomized bench for line_cmd_sequencer: a command-level reference model is
// compared against every DUT output each cycle, plus literal operand checks.

module tb_line_cmd_sequencer;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   cmd_data = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          LE_ready = 1'b1;
   logic [31:0]   LE_color;
   logic [19:0]   LE_point;
   logic          LE_color_valid;
   logic          LE_point0_valid;
   logic          LE_point1_valid;
   logic          LE_trigger;
   logic          seq_busy;
   logic          seq_error;
   logic [W-1:0]  lines_drawn;

   always #5 clk = ~clk;

   line_cmd_sequencer #(.CNT_WIDTH(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_data        (cmd_data),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .LE_ready        (LE_ready),
      .LE_color        (LE_color),
      .LE_point        (LE_point),
      .LE_color_valid  (LE_color_valid),
      .LE_point0_valid (LE_point0_valid),
      .LE_point1_valid (LE_point1_valid),
      .LE_trigger      (LE_trigger),
      .seq_busy        (seq_busy),
      .seq_error       (seq_error),
      .lines_drawn     (lines_drawn)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pt(input int x, input int y);
      logic [9:0] xs;
      logic [9:0] ys;
      xs = x[9:0];
      ys = y[9:0];
      return {12'h000, xs, ys};
   endfunction

   // Reference model. m_phase: 0 taking command words (m_need payload words
   // still owed), 1 line queued for the engine, 2..5 the four strobes in order,
   // 6 engine dead cycle, 7 waiting for the engine to finish.
   int          m_phase, m_need, m_op, m_lines;
   logic [31:0] m_color, m_le_color;
   logic [19:0] m_p0, m_p1, m_last, m_point;
   logic        m_err;

   task automatic model_reset();
      m_phase = 0; m_need = 0; m_op = 0; m_lines = 0;
      m_color = '0; m_le_color = '0;
      m_p0 = '0; m_p1 = '0; m_last = '0; m_point = '0;
      m_err = 1'b0;
   endtask

   task automatic model_step();
      case (m_phase)
         0: if (cmd_valid) begin
            if (m_need == 0) begin
               case (cmd_data[31:24])
                  8'h00: ;
                  8'h01: begin m_op = 1; m_need = 1; end
                  8'h02: begin m_op = 2; m_need = 2; end
                  8'h03: begin m_op = 3; m_need = 1; m_p0 = m_last; end
                  default: m_err = 1'b1;
               endcase
            end else if (m_op == 1) begin
               m_color = cmd_data;
               m_need  = 0;
            end else if (m_op == 2 && m_need == 2) begin
               m_p0   = cmd_data[19:0];
               m_need = 1;
            end else begin
               m_p1    = cmd_data[19:0];
               m_need  = 0;
               m_phase = 1;
            end
         end
         1: if (LE_ready) begin m_phase = 2; m_le_color = m_color; end
         2: begin m_phase = 3; m_point = m_p0; end
         3: begin m_phase = 4; m_point = m_p1; end
         4: begin m_phase = 5; m_last = m_p1; end
         5: m_phase = 6;
         6: m_phase = 7;
         7: if (LE_ready) begin m_phase = 0; m_lines = (m_lines + 1) % (1 << W); end
         default: m_phase = 0;
      endcase
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready",   32'(cmd_ready),       32'(rst && m_phase == 0));
         chk("seq_busy",    32'(seq_busy),        32'(m_phase != 0 || m_need != 0));
         chk("seq_error",   32'(seq_error),       32'(m_err));
         chk("lines_drawn", 32'(lines_drawn),     32'(m_lines));
         chk("LE_color",    LE_color,             m_le_color);
         chk("LE_point",    32'(LE_point),        32'(m_point));
         chk("color_valid", 32'(LE_color_valid),  32'(m_phase == 2));
         chk("p0_valid",    32'(LE_point0_valid), 32'(m_phase == 3));
         chk("p1_valid",    32'(LE_point1_valid), 32'(m_phase == 4));
         chk("trigger",     32'(LE_trigger),      32'(m_phase == 5));
      end
   end

   // Last operands the engine would have latched.
   logic [31:0] mon_color = '0;
   logic [19:0] mon_p0 = '0;
   logic [19:0] mon_p1 = '0;
   int          mon_trig = 0;

   always @(negedge clk) begin
      if (LE_color_valid)  mon_color = LE_color;
      if (LE_point0_valid) mon_p0 = LE_point;
      if (LE_point1_valid) mon_p1 = LE_point;
      if (LE_trigger)      mon_trig++;
   end

   // Engine model: drops ready on trigger, busy for eng_busy_len cycles.
   int eng_busy_len = 5;
   int eng_cnt = 0;
   bit le_hold = 1'b0;
   bit le_rand = 1'b0;
   bit gaps = 1'b0;

   always @(posedge clk) begin
      #2;
      if (!rst)            eng_cnt = 0;
      else if (LE_trigger) eng_cnt = eng_busy_len;
      else if (eng_cnt > 0) eng_cnt--;
      if (le_rand) LE_ready = 1'($urandom_range(0, 1));
      else         LE_ready = !le_hold && (eng_cnt == 0);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [31:0] w);
      int   n;
      logic rdy;
      n = 0;
      cmd_data  = w;
      cmd_valid = 1'b1;
      forever begin
         @(negedge clk);
         rdy = cmd_ready;
         tick();
         if (rdy) break;
         n++;
         if (n > 3000) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=no_accept required=accept word=%h", w);
            break;
         end
      end
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      if (gaps) repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (!seq_busy) break;
         n++;
         if (n > 3000) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
            break;
         end
      end
      tick();
   endtask

   task automatic do_reset(input int n);
      tick();
      rst = 1'b0;
      cmd_valid = 1'b0;
      repeat (n) tick();
      rst = 1'b1;
   endtask

   task automatic send_line(input logic [31:0] a, input logic [31:0] b);
      send(32'h0200_0000);
      send(a);
      send(b);
   endtask

   int t0, l0, n, r;
   logic [31:0] w;

   initial begin
      // Reset held with random inputs
      le_rand = 1'b1;
      tick();
      chk_en = 1'b1;
      repeat (10) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_data  = $urandom;
         tick();
      end
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_lines",     32'(lines_drawn), 32'd0);
      chk("rst_point",     32'(LE_point), 32'd0);
      tick();
      cmd_valid = 1'b0;
      le_rand = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("first_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();

      // Basic line with a slow engine
      eng_busy_len = 50;
      t0 = mon_trig;
      send(32'h0100_0000);
      send(32'h007F_0000);
      send_line(pt(1000, 700), pt(0, 0));
      wait_idle();
      chk("basic_color", mon_color, 32'h007F_0000);
      chk("basic_p0",    32'(mon_p0), 32'h000F_A2BC);
      chk("basic_p1",    32'(mon_p1), 32'd0);
      chk("basic_trig",  32'(mon_trig - t0), 32'd1);
      chk("basic_lines", 32'(lines_drawn), 32'd1);

      // LINETO chain
      eng_busy_len = 3;
      send_line(pt(0, 0), pt(400, 652));
      send(32'h0300_0000);
      send(pt(1023, 767));
      wait_idle();
      chk("lineto_p0",    32'(mon_p0), pt(400, 652));
      chk("lineto_p1",    32'(mon_p1), pt(1023, 767));
      chk("lineto_lines", 32'(lines_drawn), 32'd3);

      // LINETO right after reset starts from origin with color 0
      do_reset(3);
      send(32'h0300_0000);
      send(pt(5, 9));
      wait_idle();
      chk("rlineto_p0",    32'(mon_p0), 32'd0);
      chk("rlineto_color", mon_color, 32'd0);
      chk("rlineto_lines", 32'(lines_drawn), 32'd1);

      // Engine backpressure plus payload bubbles
      gaps = 1'b1;
      le_hold = 1'b1;
      t0 = mon_trig;
      send_line(pt(17, 33), pt(600, 2));
      repeat (20) tick();
      chk("bp_no_trigger", 32'(mon_trig), 32'(t0));
      le_hold = 1'b0;
      wait_idle();
      chk("bp_p0", 32'(mon_p0), pt(17, 33));
      chk("bp_p1", 32'(mon_p1), pt(600, 2));

      // Unknown opcode, then a normal line
      l0 = int'(lines_drawn);
      send(32'h7F00_0000);
      chk("err_set", 32'(seq_error), 32'd1);
      send_line(pt(1, 2), pt(3, 4));
      wait_idle();
      chk("err_sticky", 32'(seq_error), 32'd1);
      chk("err_line_p1", 32'(mon_p1), pt(3, 4));
      chk("err_lines", 32'(lines_drawn), 32'((l0 + 1) % (1 << W)));

      // Reset while in GET_P1
      gaps = 1'b0;
      send(32'h0100_0000);
      send(32'h00AB_CDEF);
      send(32'h0200_0000);
      send(pt(9, 9));
      t0 = mon_trig;
      tick();
      rst = 1'b0;
      #1;
      chk("abort_p1_busy",  32'(seq_busy), 32'd0);
      chk("abort_p1_ready", 32'(cmd_ready), 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk("abort_p1_notrig", 32'(mon_trig), 32'(t0));

      // Reset while in WAIT_DONE
      eng_busy_len = 30;
      t0 = mon_trig;
      send_line(pt(100, 200), pt(300, 400));
      n = 0;
      while (mon_trig == t0 && n < 100) begin tick(); n++; end
      repeat (4) tick();
      rst = 1'b0;
      #1;
      chk("abort_wd_lines", 32'(lines_drawn), 32'd0);
      chk("abort_wd_point", 32'(LE_point), 32'd0);
      chk("abort_wd_busy",  32'(seq_busy), 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      eng_busy_len = 4;
      t0 = mon_trig;
      send_line(pt(11, 22), pt(33, 44));
      wait_idle();
      chk("post_rst_color", mon_color, 32'd0);
      chk("post_rst_trig",  32'(mon_trig - t0), 32'd1);
      chk("post_rst_p0",    32'(mon_p0), pt(11, 22));

      // Random command stream (lines_drawn wraps several times)
      gaps = 1'b1;
      for (int i = 0; i < 400; i++) begin
         eng_busy_len = $urandom_range(0, 8);
         if ($urandom_range(0, 15) == 0) le_rand = ~le_rand;
         r = $urandom_range(0, 19);
         if (r == 19) begin
            do_reset($urandom_range(1, 3));
         end else if (r < 2) begin
            send($urandom & 32'h00FF_FFFF);
         end else if (r < 5) begin
            send(32'h0100_0000 | ($urandom & 32'h00FF_FFFF));
            send($urandom);
         end else if (r < 11) begin
            send(32'h0200_0000 | ($urandom & 32'h00FF_FFFF));
            send($urandom);
            send($urandom);
         end else if (r < 17) begin
            send(32'h0300_0000 | ($urandom & 32'h00FF_FFFF));
            send($urandom);
         end else begin
            w = $urandom;
            w[31:24] = 8'($urandom_range(4, 255));
            send(w);
         end
      end
      le_rand = 1'b0;
      wait_idle();
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
